// File: rtl/baccarat_round_ctrl.sv
// rtl/baccarat_round_ctrl.sv - baccarat round sequencer with card handshake and saturating tallies
//
// Ports:
//   slow_clock        rising-edge clock
//   reset             asynchronous active-high reset
//   start             begin a round (only looked at in IDLE)
//   card_valid        card source has a card this cycle
//   pscore, dscore    player / dealer hand score mod 10 from the datapath
//   pcard3            player third-card value, valid after the P3 load
//   card_req          high in every draw state
//   load_card         one-hot load strobe [0]=p1 [1]=d1 [2]=p2 [3]=d2 [4]=p3 [5]=d3
//   player_win_light  player won or tie
//   dealer_win_light  dealer won or tie
//   round_done        one-cycle pulse on entry to HOLD
//   busy              high outside IDLE
//   player_wins, dealer_wins, ties, rounds   saturating tallies (CNT_W bits)

module baccarat_round_ctrl #(
   parameter int CNT_W       = 8,
   parameter int HOLD_CYCLES = 4,
   parameter int AUTO_NEXT   = 0
) (
   input  logic             slow_clock,
   input  logic             reset,
   input  logic             start,
   input  logic             card_valid,
   input  logic [3:0]       pscore,
   input  logic [3:0]       dscore,
   input  logic [3:0]       pcard3,
   output logic             card_req,
   output logic [5:0]       load_card,
   output logic             player_win_light,
   output logic             dealer_win_light,
   output logic             round_done,
   output logic             busy,
   output logic [CNT_W-1:0] player_wins,
   output logic [CNT_W-1:0] dealer_wins,
   output logic [CNT_W-1:0] ties,
   output logic [CNT_W-1:0] rounds
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_DRAW,
      S_SETTLE,
      S_DECIDE_P,
      S_DRAW_P3,
      S_SETTLE_P3,
      S_DECIDE_D,
      S_DRAW_D3,
      S_SETTLE_D3,
      S_RESULT,
      S_HOLD
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [1:0] k;
   logic [7:0] hold_cnt;
   logic       hold_done;
   logic       restart;
   logic       natural;
   logic       dealer_draws;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   assign hold_done = (hold_cnt == HOLD_LAST);
   assign restart   = hold_done && (AUTO_NEXT != 0);

   // Scores above 9 also land here, so out-of-range hands stand without drawing.
   assign natural = (pscore >= 4'd8) || (dscore >= 4'd8);

   // Dealer third-card rule, keyed on dealer score and the player's third card.
   always_comb begin
      dealer_draws = 1'b0;
      case (dscore)
         4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
         4'd3:             dealer_draws = (pcard3 != 4'd8);
         4'd4:             dealer_draws = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
         4'd5:             dealer_draws = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
         4'd6:             dealer_draws = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
         default:          dealer_draws = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (start) state_next = S_DRAW;
         S_DRAW:      if (card_valid) state_next = S_SETTLE;
         S_SETTLE:    state_next = (k == 2'd3) ? S_DECIDE_P : S_DRAW;
         S_DECIDE_P: begin
            if (natural)
               state_next = S_RESULT;
            else if (pscore <= 4'd5)
               state_next = S_DRAW_P3;
            else if (dscore <= 4'd5)
               state_next = S_DRAW_D3;
            else
               state_next = S_RESULT;
         end
         S_DRAW_P3:   if (card_valid) state_next = S_SETTLE_P3;
         S_SETTLE_P3: state_next = S_DECIDE_D;
         S_DECIDE_D:  state_next = dealer_draws ? S_DRAW_D3 : S_RESULT;
         S_DRAW_D3:   if (card_valid) state_next = S_SETTLE_D3;
         S_SETTLE_D3: state_next = S_RESULT;
         S_RESULT:    state_next = S_HOLD;
         S_HOLD: begin
            if (hold_done) state_next = (AUTO_NEXT != 0) ? S_DRAW : S_IDLE;
         end
         default:     state_next = S_IDLE;
      endcase
   end

   // Outputs: strobes are combinational so a load lasts exactly the handshake cycle.
   always_comb begin
      card_req   = 1'b0;
      load_card  = 6'b000000;
      round_done = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_DRAW: begin
            card_req       = 1'b1;
            load_card[3:0] = card_valid ? (4'b0001 << k) : 4'b0000;
         end
         S_DRAW_P3: begin
            card_req     = 1'b1;
            load_card[4] = card_valid;
         end
         S_DRAW_D3: begin
            card_req     = 1'b1;
            load_card[5] = card_valid;
         end
         S_HOLD:  round_done = (hold_cnt == 8'd0);
         default: ;
      endcase
   end

   // Deal index, hold timer, lights and tallies
   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         k                <= 2'd0;
         hold_cnt         <= 8'd0;
         player_win_light <= 1'b0;
         dealer_win_light <= 1'b0;
         player_wins      <= '0;
         dealer_wins      <= '0;
         ties             <= '0;
         rounds           <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               k <= 2'd0;
               if (start) begin
                  player_win_light <= 1'b0;
                  dealer_win_light <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (k != 2'd3) k <= k + 2'd1;
            end
            S_RESULT: begin
               hold_cnt         <= 8'd0;
               player_win_light <= (pscore >= dscore);
               dealer_win_light <= (dscore >= pscore);
               rounds           <= sat_inc(rounds);
               if (pscore > dscore)
                  player_wins <= sat_inc(player_wins);
               else if (pscore < dscore)
                  dealer_wins <= sat_inc(dealer_wins);
               else
                  ties <= sat_inc(ties);
            end
            S_HOLD: begin
               k        <= 2'd0;
               hold_cnt <= hold_cnt + 8'd1;
               if (restart) begin
                  player_win_light <= 1'b0;
                  dealer_win_light <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// tb/tb_baccarat_round_ctrl.sv - randomized round bench for baccarat_round_ctrl
module tb_baccarat_round_ctrl;

   localparam int HOLD_MAIN = 3;
   localparam int TALLY_MAX = 255;

   logic       slow_clock = 1'b0;
   logic       reset;
   logic       start, card_valid;
   logic [3:0] pscore, dscore, pcard3;
   logic       card_req;
   logic [5:0] load_card;
   logic       player_win_light, dealer_win_light, round_done, busy;
   logic [7:0] player_wins, dealer_wins, ties, rounds;

   logic       a_start, a_card_valid;
   logic [3:0] a_pscore, a_dscore, a_pcard3;
   logic       a_card_req;
   logic [5:0] a_load_card;
   logic       a_player_win_light, a_dealer_win_light, a_round_done, a_busy;
   logic [1:0] a_player_wins, a_dealer_wins, a_ties, a_rounds;

   int n_vec = 0;
   int n_bad = 0;
   int exp_pw = 0, exp_dw = 0, exp_tie = 0, exp_rnd = 0;

   always #5 slow_clock = ~slow_clock;

   baccarat_round_ctrl #(.CNT_W(8), .HOLD_CYCLES(HOLD_MAIN), .AUTO_NEXT(0)) u_dut (
      .slow_clock(slow_clock), .reset(reset), .start(start), .card_valid(card_valid),
      .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
      .card_req(card_req), .load_card(load_card),
      .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
      .round_done(round_done), .busy(busy),
      .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties), .rounds(rounds)
   );

   baccarat_round_ctrl #(.CNT_W(2), .HOLD_CYCLES(2), .AUTO_NEXT(1)) u_auto (
      .slow_clock(slow_clock), .reset(reset), .start(a_start), .card_valid(a_card_valid),
      .pscore(a_pscore), .dscore(a_dscore), .pcard3(a_pcard3),
      .card_req(a_card_req), .load_card(a_load_card),
      .player_win_light(a_player_win_light), .dealer_win_light(a_dealer_win_light),
      .round_done(a_round_done), .busy(a_busy),
      .player_wins(a_player_wins), .dealer_wins(a_dealer_wins), .ties(a_ties), .rounds(a_rounds)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v < mx) ? v + 1 : mx;
   endfunction

   // Whole-round outcome from the rules of the game: who draws a third card and final scores.
   task automatic ref_round(input int ps0, input int ds0, input int pc3, input int ps1,
                            input int ds1, output bit p3, output bit d3,
                            output int fp, output int fd);
      bit [9:0] d3_tbl [8];
      // bit n of entry s: dealer on s draws when the player's third card is n
      d3_tbl = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC, 10'h0F0, 10'h0C0, 10'h000};
      p3 = 1'b0;
      d3 = 1'b0;
      if (ps0 >= 8 || ds0 >= 8) begin
         p3 = 1'b0;
      end else if (ps0 <= 5) begin
         p3 = 1'b1;
         d3 = d3_tbl[ds0][pc3];
      end else begin
         d3 = (ds0 <= 5);
      end
      fp = p3 ? ps1 : ps0;
      fd = d3 ? ds1 : ds0;
   endtask

   task automatic run_round(input int ps0, input int ds0, input int pc3, input int ps1,
                            input int ds1, input int stall_idx);
      int  exp_q[$];
      bit  p3, d3;
      int  fp, fd, idx, sl, exp_pl, exp_dl;
      int  seen_done = 0, done_cyc = 0, stall_left = 0;
      bit  after_strobe = 0, first = 1, finished = 0;
      bit  pend_init = 0, pend_p3 = 0, pend_d3 = 0;

      ref_round(ps0, ds0, pc3, ps1, ds1, p3, d3, fp, fd);
      exp_q = {0, 1, 2, 3};
      if (p3) exp_q.push_back(4);
      if (d3) exp_q.push_back(5);
      exp_pl  = (fp >= fd) ? 1 : 0;
      exp_dl  = (fd >= fp) ? 1 : 0;
      exp_rnd = sat(exp_rnd, TALLY_MAX);
      if (fp > fd)      exp_pw  = sat(exp_pw, TALLY_MAX);
      else if (fp < fd) exp_dw  = sat(exp_dw, TALLY_MAX);
      else              exp_tie = sat(exp_tie, TALLY_MAX);

      pscore     = 4'($urandom_range(0, 15));
      dscore     = 4'($urandom_range(0, 15));
      pcard3     = 4'($urandom_range(0, 9));
      start      = 1'b1;
      card_valid = 1'b0;
      for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
         @(posedge slow_clock);
         #1;
         // datapath: scores reflect a load one cycle after its strobe
         if (pend_init) begin pscore = 4'(ps0); dscore = 4'(ds0); pend_init = 0; end
         if (pend_p3)   begin pscore = 4'(ps1); pcard3 = 4'(pc3); pend_p3 = 0; end
         if (pend_d3)   begin dscore = 4'(ds1); pend_d3 = 0; end
         start = 1'($urandom_range(0, 1));
         sl = stall_left;
         if (stall_left > 0) begin
            card_valid = 1'b0;
            stall_left--;
         end else if (after_strobe) begin
            card_valid = 1'b1;
         end else begin
            card_valid = ($urandom_range(0, 3) != 0);
         end
         #1;
         if (sl > 0 && sl <= 10) check("stall_req", int'(card_req), 1);
         if (!card_valid) begin
            check("no_valid_no_load", int'(load_card), 0);
         end else if (after_strobe) begin
            check("settle_gap", int'(load_card), 0);
         end else if (load_card != 6'd0) begin
            idx = (exp_q.size() > 0) ? exp_q.pop_front() : 7;
            check("strobe_order", int'(load_card), (idx < 6) ? (1 << idx) : 0);
            if (first) begin
               check("lights_clr_p", int'(player_win_light), 0);
               check("lights_clr_d", int'(dealer_win_light), 0);
               first = 0;
            end
            pend_init = (idx == 3);
            pend_p3   = (idx == 4);
            pend_d3   = (idx == 5);
            if (idx == stall_idx - 1) stall_left = 11;
         end
         after_strobe = (load_card != 6'd0);
         if (round_done) begin
            seen_done++;
            done_cyc = cyc;
            check("p_light", int'(player_win_light), exp_pl);
            check("d_light", int'(dealer_win_light), exp_dl);
            check("player_wins", int'(player_wins), exp_pw);
            check("dealer_wins", int'(dealer_wins), exp_dw);
            check("ties", int'(ties), exp_tie);
            check("rounds", int'(rounds), exp_rnd);
         end
         if (!busy) begin
            start = 1'b0;
            check("done_once", seen_done, 1);
            check("hold_len", cyc - done_cyc, HOLD_MAIN);
            check("idle_p_light", int'(player_win_light), exp_pl);
            check("idle_d_light", int'(dealer_win_light), exp_dl);
            check("strobes_left", exp_q.size(), 0);
            finished = 1;
         end
      end
      if (!finished) begin
         start = 1'b0;
         check("round_timeout", 0, 1);
      end
   endtask

   task automatic reset_mid_round();
      int n = 0;
      start      = 1'b1;
      card_valid = 1'b1;
      for (int c = 0; c < 40 && n < 3; c++) begin
         @(posedge slow_clock);
         #1;
         start = 1'b0;
         #1;
         if (load_card != 6'd0) n++;
      end
      check("pre_reset_loads", n, 3);
      card_valid = 1'b0;
      @(posedge slow_clock);
      @(posedge slow_clock);
      #2;
      check("k3_req", int'(card_req), 1);
      check("k3_no_load", int'(load_card), 0);
      #1;
      reset = 1'b1;
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_req", int'(card_req), 0);
      check("rst_load", int'(load_card), 0);
      check("rst_p_light", int'(player_win_light), 0);
      check("rst_d_light", int'(dealer_win_light), 0);
      check("rst_done", int'(round_done), 0);
      check("rst_pwins", int'(player_wins), 0);
      check("rst_dwins", int'(dealer_wins), 0);
      check("rst_ties", int'(ties), 0);
      check("rst_rounds", int'(rounds), 0);
      exp_pw = 0; exp_dw = 0; exp_tie = 0; exp_rnd = 0;
      @(posedge slow_clock);
      #1;
      reset = 1'b0;
      @(posedge slow_clock);
      #1;
      check("post_reset_idle", int'(busy), 0);
   endtask

   task automatic auto_test();
      int done_n = 0, last_done = -1;
      bit dropped = 0;
      a_pscore     = 4'd8;
      a_dscore     = 4'd3;
      a_pcard3     = 4'd0;
      a_card_valid = 1'b1;
      a_start      = 1'b1;
      for (int c = 0; c < 400 && done_n < 5; c++) begin
         @(posedge slow_clock);
         #1;
         a_start = 1'b0;
         #1;
         if (!a_busy) dropped = 1;
         if (a_round_done) begin
            done_n++;
            check("auto_pwins", int'(a_player_wins), (done_n < 3) ? done_n : 3);
            check("auto_rounds", int'(a_rounds), (done_n < 3) ? done_n : 3);
            check("auto_p_light", int'(a_player_win_light), 1);
            check("auto_d_light", int'(a_dealer_win_light), 0);
            last_done = c;
         end
         if (a_load_card[0] && last_done >= 0) begin
            check("auto_restart", c - last_done, 2);
            last_done = -1;
         end
      end
      check("auto_rounds_seen", done_n, 5);
      check("auto_no_idle", int'(dropped), 0);
      check("auto_dwins", int'(a_dealer_wins), 0);
      check("auto_ties", int'(a_ties), 0);
   endtask

   function automatic int rand_score();
      return ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
   endfunction

   task automatic random_rounds(input int n);
      for (int i = 0; i < n; i++) begin
         run_round(rand_score(), rand_score(), int'($urandom_range(0, 9)),
                   int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : -1);
      end
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      card_valid   = 1'b1;
      pscore       = 4'd0;
      dscore       = 4'd0;
      pcard3       = 4'd0;
      a_start      = 1'b0;
      a_card_valid = 1'b0;
      a_pscore     = 4'd0;
      a_dscore     = 4'd0;
      a_pcard3     = 4'd0;
      repeat (3) @(posedge slow_clock);
      #2;
      check("init_busy", int'(busy), 0);
      check("init_req", int'(card_req), 0);
      check("init_load", int'(load_card), 0);
      check("init_p_light", int'(player_win_light), 0);
      check("init_d_light", int'(dealer_win_light), 0);
      check("init_done", int'(round_done), 0);
      check("init_rounds", int'(rounds), 0);
      check("init_pwins", int'(player_wins), 0);
      check("init_auto_busy", int'(a_busy), 0);
      check("init_auto_rounds", int'(a_rounds), 0);
      @(posedge slow_clock);
      #1;
      reset      = 1'b0;
      card_valid = 1'b0;

      run_round(8, 3, 0, 0, 0, 2);
      run_round(4, 3, 8, 2, 0, -1);
      run_round(4, 6, 7, 5, 5, -1);
      run_round(7, 5, 0, 0, 9, -1);
      run_round(6, 6, 0, 0, 0, -1);
      random_rounds(30);
      reset_mid_round();
      random_rounds(3);
      auto_test();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
